// File: rtl/door_controller.sv
// door_controller: door sequencing FSM timed by door_clk ticks, gating car motion
module door_controller #(
  parameter int TRAVEL_TICKS = 1,
  parameter int OPEN_TICKS   = 2,
  parameter int MAX_REOPEN   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       door_clk,
  input  logic       open_req,
  input  logic       obstruction,
  input  logic       weight_limit_exceeded,
  output logic       timer_restart,
  output logic       door_open,
  output logic       door_closed,
  output logic       motion_enable,
  output logic       reopen_limit,
  output logic [1:0] door_state
);
  localparam logic [1:0] CLOSED     = 2'b00;
  localparam logic [1:0] OPENING    = 2'b01;
  localparam logic [1:0] OPEN       = 2'b10;
  localparam logic [1:0] CLOSING    = 2'b11;
  localparam logic [7:0] TRAVEL     = 8'(TRAVEL_TICKS);
  localparam logic [7:0] DWELL      = 8'(OPEN_TICKS);
  localparam logic [3:0] REOPEN_MAX = 4'(MAX_REOPEN);
  logic [1:0] r_state, w_next;
  logic [7:0] r_cnt, w_cnt, w_cnt_inc;
  logic [3:0] r_reopen, w_reopen;
  logic       r_door_clk_q, w_tick, w_dwell_restart, w_entry;
  logic       r_timer_restart, r_door_open, r_door_closed, r_motion_enable, r_reopen_limit;
  logic       w_timer_restart, w_door_open, w_door_closed, w_motion_enable, w_reopen_limit;
  assign w_tick    = door_clk & ~r_door_clk_q;
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_entry   = w_next != r_state;
  // State, tick counter, reopen counter and door_clk edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= CLOSED;
      r_cnt        <= '0;
      r_reopen     <= '0;
      r_door_clk_q <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt;
      r_reopen     <= w_reopen;
      r_door_clk_q <= door_clk;
    end
  end
  // Next state; the tick counter restarts on every state entry and on a dwell restart
  always_comb begin
    w_next          = r_state;
    w_cnt           = r_cnt;
    w_reopen        = r_reopen;
    w_dwell_restart = 1'b0;
    case (r_state)
      CLOSED:  w_next = open_req ? OPENING : CLOSED;
      OPENING: begin
        if (w_tick) begin
          w_cnt  = w_cnt_inc;
          w_next = (w_cnt_inc == TRAVEL) ? OPEN : OPENING;
        end
      end
      OPEN: begin
        if (!weight_limit_exceeded) begin
          if (open_req) begin
            w_dwell_restart = 1'b1;
          end else if (w_tick) begin
            w_cnt  = w_cnt_inc;
            w_next = (w_cnt_inc == DWELL) ? CLOSING : OPEN;
          end
        end
      end
      CLOSING: begin
        if (obstruction || weight_limit_exceeded) begin
          w_next = OPENING;
        end else if (open_req && r_reopen < REOPEN_MAX) begin
          w_next   = OPENING;
          w_reopen = r_reopen + 4'd1;
        end else if (w_tick) begin
          w_cnt = w_cnt_inc;
          if (w_cnt_inc == TRAVEL) begin
            w_next   = CLOSED;
            w_reopen = '0;
          end
        end
      end
    endcase
    if (w_entry || w_dwell_restart) w_cnt = '0;
  end
  // Output values as they will look once the next state is registered
  always_comb begin
    w_timer_restart = w_entry | w_dwell_restart;
    w_door_open     = w_next == OPEN;
    w_door_closed   = w_next == CLOSED;
    w_motion_enable = (w_next == CLOSED) & ~weight_limit_exceeded;
    w_reopen_limit  = w_reopen == REOPEN_MAX;
  end
  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer_restart <= 1'b0;
      r_door_open     <= 1'b0;
      r_door_closed   <= 1'b1;
      r_motion_enable <= 1'b1;
      r_reopen_limit  <= 1'b0;
    end else begin
      r_timer_restart <= w_timer_restart;
      r_door_open     <= w_door_open;
      r_door_closed   <= w_door_closed;
      r_motion_enable <= w_motion_enable;
      r_reopen_limit  <= w_reopen_limit;
    end
  end
  assign timer_restart = r_timer_restart;
  assign door_open     = r_door_open;
  assign door_closed   = r_door_closed;
  assign motion_enable = r_motion_enable;
  assign reopen_limit  = r_reopen_limit;
  assign door_state    = r_state;
endmodule
